// File: rtl/csa_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : csa_pkg
//  Description : Shared definitions for the multi-precision add/subtract
//                sequencer: adder slice width and sequencer state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package csa_pkg;

    // Width of one adder slice; the sequencer walks operands in these units.
    localparam int SLICE_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

endpackage : csa_pkg
`default_nettype wire

// File: rtl/carry_select_adder.sv
`default_nettype none
// ============================================================================
//  Module      : carry_select_adder
//  Description : 16-bit carry-select adder. The low 4-bit block ripples from
//                cin; each higher 4-bit block precomputes its sum for both
//                carry-in values and the incoming block carry picks one.
//  Ports       : A, B  - addends
//                cin   - carry in
//                S     - sum
//                cout  - carry out of bit 15
//  Revision    : 1.0 - initial release
// ============================================================================
module carry_select_adder (
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        cin,
    output logic [15:0] S,
    output logic        cout
);

    localparam int c_BLK_W = 4;
    localparam int c_NBLK  = 16 / c_BLK_W;

    // w_c[k] is the carry into block k.
    logic [c_NBLK:0] w_c;

    assign w_c[0] = cin;

    generate
        for (genvar g = 0; g < c_NBLK; g++) begin : g_blk
            if (g == 0) begin : g_ripple
                assign {w_c[1], S[c_BLK_W-1:0]} = {1'b0, A[c_BLK_W-1:0]}
                                                + {1'b0, B[c_BLK_W-1:0]}
                                                + {{c_BLK_W{1'b0}}, w_c[0]};
            end else begin : g_select
                logic [c_BLK_W:0] w_sum0;
                logic [c_BLK_W:0] w_sum1;

                assign w_sum0 = {1'b0, A[g*c_BLK_W +: c_BLK_W]}
                              + {1'b0, B[g*c_BLK_W +: c_BLK_W]};
                assign w_sum1 = {1'b0, A[g*c_BLK_W +: c_BLK_W]}
                              + {1'b0, B[g*c_BLK_W +: c_BLK_W]}
                              + {{c_BLK_W{1'b0}}, 1'b1};

                assign {w_c[g+1], S[g*c_BLK_W +: c_BLK_W]} = w_c[g] ? w_sum1 : w_sum0;
            end
        end
    endgenerate

    assign cout = w_c[c_NBLK];

endmodule : carry_select_adder
`default_nettype wire

// File: rtl/csa_word_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : csa_word_sequencer
//  Description : Multi-precision add/subtract built around one 16-bit
//                carry_select_adder. An accepted operand pair is processed
//                one slice per cycle, LSB slice first, with the carry chained
//                through a register. The full result and final carry are
//                returned on an output valid/ready handshake.
//  Ports       : clk, rst_n            - clock, async active-low reset
//                in_valid/in_ready     - operand handshake (ready in IDLE only)
//                op_sub, a, b          - operation and operands, sampled at accept
//                out_valid/out_ready   - result handshake
//                sum, cout             - result and final carry
//                                        (subtract: cout=1 means no borrow)
//  Revision    : 1.0 - initial release
// ============================================================================
module csa_word_sequencer
    import csa_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     op_sub,
    input  logic [SLICE_W*WORDS-1:0] a,
    input  logic [SLICE_W*WORDS-1:0] b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SLICE_W*WORDS-1:0] sum,
    output logic                     cout
);

    localparam int                 c_N     = SLICE_W * WORDS;
    localparam int                 c_IDX_W = $clog2(WORDS);
    localparam logic [c_IDX_W-1:0] c_LAST  = c_IDX_W'(WORDS - 1);

    seq_state_t         r_state;
    logic [c_N-1:0]     r_a;
    logic [c_N-1:0]     r_b;
    logic [c_N-1:0]     r_sum;
    logic [c_IDX_W-1:0] r_idx;
    logic               r_carry;
    logic               r_cout;
    logic               r_in_ready;
    logic               r_out_valid;

    // Bit offset of the current slice: idx * 16.
    logic [c_IDX_W+3:0] w_base;
    logic [SLICE_W-1:0] w_a_sl;
    logic [SLICE_W-1:0] w_b_sl;
    logic [SLICE_W-1:0] w_s;
    logic               w_cout;

    assign w_base = {r_idx, 4'b0000};
    assign w_a_sl = r_a[w_base +: SLICE_W];
    assign w_b_sl = r_b[w_base +: SLICE_W];

    carry_select_adder u_adder (
        .A    (w_a_sl),
        .B    (w_b_sl),
        .cin  (r_carry),
        .S    (w_s),
        .cout (w_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_cout      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtract is A + ~B + 1: invert B once here and
                        // seed the carry chain with the +1.
                        r_a        <= a;
                        r_b        <= op_sub ? ~b : b;
                        r_carry    <= op_sub;
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    r_sum[w_base +: SLICE_W] <= w_s;
                    r_carry                  <= w_cout;
                    if (r_idx == c_LAST) begin
                        r_cout      <= w_cout;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;

endmodule : csa_word_sequencer
`default_nettype wire

// File: tb/tb_csa_word_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_csa_word_sequencer
//  Description : Self-checking bench for csa_word_sequencer. A WORDS=4
//                instance gets directed vectors, backpressure, mid-run reset
//                and randomized throttled traffic checked against an
//                arithmetic reference; a WORDS=2 instance gets a latency and
//                carry check.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_csa_word_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        in_valid, in_ready, op_sub, out_valid, out_ready, cout;
    logic [63:0] a, b, sum;

    logic        in_valid2, in_ready2, op_sub2, out_valid2, out_ready2, cout2;
    logic [31:0] a2, b2, sum2;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    csa_word_sequencer #(.WORDS(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .op_sub(op_sub),
        .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout)
    );

    csa_word_sequencer #(.WORDS(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid2), .in_ready(in_ready2), .op_sub(op_sub2),
        .a(a2), .b(b2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .sum(sum2), .cout(cout2)
    );

    // Reference: plain unsigned arithmetic; {carry, result}.
    function automatic logic [64:0] ref64(input logic [63:0] x, input logic [63:0] y, input logic s);
        logic [64:0] r;
        if (s) begin
            r[63:0] = x - y;
            r[64]   = (x >= y);
        end else begin
            r = {1'b0, x} + {1'b0, y};
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // One complete transaction on the WORDS=4 instance with immediate drain.
    task automatic run_op(input logic [63:0] ia, input logic [63:0] ib, input logic isub,
                          output logic [64:0] res, output int lat);
        int guard;
        @(negedge clk);
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) timeout("run_op in_ready");
        in_valid = 1'b1; a = ia; b = ib; op_sub = isub; out_ready = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat   = 1;
        guard = 0;
        @(negedge clk);
        while (!out_valid && guard < 50) begin
            lat++;
            guard++;
            @(negedge clk);
        end
        if (!out_valid) timeout("run_op out_valid");
        res = {cout, sum};
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        sub;
        logic [63:0] s;
        logic        c;
        int          lat;
    } vec_t;

    vec_t tbl[9];

    initial begin
        logic [64:0] res, snap, expv;
        logic [64:0] q[$];
        logic [63:0] ra, rb;
        logic        rs, acc, hs, ov_seen;
        int          lat, guard, acc_n, rcv_n, cyc;

        tbl[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1,                   1'b0, 64'h0,                   1'b1, 5};
        tbl[1] = '{64'h0,                   64'h1,                   1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 5};
        tbl[2] = '{64'h5,                   64'h3,                   1'b1, 64'h2,                   1'b1, 5};
        tbl[3] = '{64'h1234,                64'h4321,                1'b0, 64'h5555,                1'b0, 5};
        tbl[4] = '{64'h0000_0000_0000_FFFF, 64'h1,                   1'b0, 64'h0000_0000_0001_0000, 1'b0, 5};
        tbl[5] = '{64'h0000_0000_0001_0000, 64'h1,                   1'b1, 64'h0000_0000_0000_FFFF, 1'b1, 5};
        tbl[6] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0,                   1'b1, 5};
        tbl[7] = '{64'h7,                   64'h7,                   1'b1, 64'h0,                   1'b1, 5};
        tbl[8] = '{64'h0000_FFFF_0000_0000, 64'h0000_0001_0000_0000, 1'b0, 64'h0001_0000_0000_0000, 1'b0, 5};

        in_valid = 0; op_sub = 0; a = '0; b = '0; out_ready = 0;
        in_valid2 = 0; op_sub2 = 0; a2 = '0; b2 = '0; out_ready2 = 0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset in_ready",  65'(in_ready),  65'd1);
        check("reset out_valid", 65'(out_valid), 65'd0);
        check("reset sum",       65'(sum),       65'd0);
        check("reset cout",      65'(cout),      65'd0);
        check("reset2 in_ready", 65'(in_ready2), 65'd1);
        check("reset2 out_valid",65'(out_valid2),65'd0);
        rst_n = 1'b1;

        // Directed vectors
        for (int i = 0; i < 9; i++) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].sub, res, lat);
            check($sformatf("vec%0d sum", i),  65'(res[63:0]), 65'(tbl[i].s));
            check($sformatf("vec%0d cout", i), 65'(res[64]),   65'(tbl[i].c));
            check($sformatf("vec%0d lat", i),  65'(lat),       65'(tbl[i].lat));
        end

        // Backpressure: result held, in_ready low, new in_valid ignored
        expv = ref64(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0);
        @(negedge clk);
        in_valid = 1'b1; a = 64'h0123_4567_89AB_CDEF; b = 64'h1111_1111_1111_1111; op_sub = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        guard = 0;
        @(negedge clk);
        while (!out_valid && guard < 50) begin
            guard++;
            @(negedge clk);
        end
        if (!out_valid) timeout("bp out_valid");
        check("bp result", {cout, sum}, expv);
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; a = '1; b = '1; op_sub = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("bp hold%0d result", k),    {cout, sum},       expv);
            check($sformatf("bp hold%0d in_ready", k),  65'(in_ready),     65'd0);
            check($sformatf("bp hold%0d out_valid", k), 65'(out_valid),    65'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("bp release in_ready",  65'(in_ready),  65'd1);
        check("bp release out_valid", 65'(out_valid), 65'd0);
        @(negedge clk);
        check("bp nothing queued", 65'(in_ready), 65'd1);

        // Reset during RUN cycle 2
        @(negedge clk);
        in_valid = 1'b1; a = 64'hDEAD_BEEF_CAFE_F00D; b = 64'h1; op_sub = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst in_ready",  65'(in_ready),  65'd1);
        check("midrst out_valid", 65'(out_valid), 65'd0);
        check("midrst sum",       65'(sum),       65'd0);
        check("midrst cout",      65'(cout),      65'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        ov_seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            ov_seen = ov_seen | out_valid;
        end
        check("midrst no out_valid", 65'(ov_seen), 65'd0);
        run_op(64'h1234, 64'h4321, 1'b0, res, lat);
        check("post-rst result", res, {1'b0, 64'h5555});

        // Randomized throttled traffic
        acc_n = 0; rcv_n = 0; cyc = 0;
        ra = '0; rb = '0; rs = 1'b0;
        while ((acc_n < 1000 || rcv_n < 1000) && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            if (acc_n < 1000 && $urandom_range(0, 3) != 0) begin
                ra = {$urandom, $urandom};
                rb = {$urandom, $urandom};
                rs = 1'($urandom_range(0, 1));
                in_valid = 1'b1; a = ra; b = rb; op_sub = rs;
            end else begin
                in_valid = 1'b0;
            end
            out_ready = ($urandom_range(0, 2) != 0);
            acc  = in_valid & in_ready;
            hs   = out_valid & out_ready;
            snap = {cout, sum};
            @(posedge clk);
            if (acc) begin
                q.push_back(ref64(ra, rb, rs));
                acc_n++;
            end
            if (hs) begin
                rcv_n++;
                if (q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL rnd extra result: got %h, expected none", snap);
                end else begin
                    check($sformatf("rnd result %0d", rcv_n), snap, q.pop_front());
                end
            end
        end
        #1 in_valid = 1'b0; out_ready = 1'b0;
        check("rnd received count", 65'(rcv_n), 65'd1000);
        check("rnd pending", 65'(q.size()), 65'd0);

        // WORDS=2 instance: carry out of the top slice, 3-cycle latency
        @(negedge clk);
        in_valid2 = 1'b1; a2 = 32'h8000_0000; b2 = 32'h8000_0000; op_sub2 = 1'b0;
        @(posedge clk);
        #1 in_valid2 = 1'b0;
        lat   = 1;
        guard = 0;
        @(negedge clk);
        while (!out_valid2 && guard < 20) begin
            lat++;
            guard++;
            @(negedge clk);
        end
        if (!out_valid2) timeout("w2 out_valid");
        check("w2 sum",  65'(sum2),  65'd0);
        check("w2 cout", 65'(cout2), 65'd1);
        check("w2 lat",  65'(lat),   65'd3);
        out_ready2 = 1'b1;
        @(posedge clk);
        #1 out_ready2 = 1'b0;
        @(negedge clk);
        check("w2 in_ready after", 65'(in_ready2), 65'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_csa_word_sequencer
`default_nettype wire

// File: doc/csa_word_sequencer.md
# csa_word_sequencer

Multi-precision add/subtract sequencer built around a single 16-bit `carry_select_adder`. It accepts one `WORDS`×16-bit operand pair through a valid/ready handshake and feeds the shared adder one 16-bit slice per cycle, LSB word first, chaining the carry through a register. It returns the full-width result and final carry on a second valid/ready handshake. The block sits between the FPU mantissa/exponent datapath and the adder, so one small adder can serve wide operations.

## Interface
Parameters:
- `WORDS`, 4, number of 16-bit slices per operation (≥2); operand width N = 16·WORDS.

Ports:
- `clk` in 1, sole clock, rising edge.
- `rst_n` in 1, asynchronous active-low reset.
- `in_valid` in 1, operand pair presented.
- `in_ready` out 1, sequencer can accept (IDLE only).
- `op_sub` in 1, 0 = A+B, 1 = A−B; sampled at accept.
- `a` in N, operand A; sampled at accept.
- `b` in N, operand B; sampled at accept.
- `out_valid` out 1, result available.
- `out_ready` in 1, consumer takes result.
- `sum` out N, result, two's-complement wrap.
- `cout` out 1, final carry; for subtract, 1 = no borrow (A ≥ B unsigned).

## Operation
- States: IDLE, RUN, DONE.
- IDLE: `in_ready`=1. On `in_valid & in_ready`:
  - latch `a`; latch `b` (or `~b` if `op_sub`).
  - carry register ← `op_sub`.
  - word index ← 0.
  - go to RUN.
- RUN, each cycle:
  - adder A = slice[idx] of latched A; adder B = slice[idx] of latched B; adder cin = carry register.
  - adder S → `sum` slice[idx]; adder cout → carry register.
  - idx increments. After slice WORDS−1, go to DONE.
- DONE: `out_valid`=1. `sum` and `cout` are held stable until `out_ready`, then the block returns to IDLE.
- `cout` equals the carry register after the last slice.
- `in_valid` is ignored outside IDLE; no input buffering.
- No combinational path from `in_valid` or `out_ready` to any output.

## Timing
- Accept edge = cycle 0. RUN occupies cycles 1..WORDS. `out_valid` rises at cycle WORDS+1.
- Minimum issue interval is WORDS+2 cycles, because `in_ready` is low in RUN and DONE.
- When `out_valid & out_ready` is seen at an edge, `in_ready` is 1 on the following cycle.
- Reset values:
  - `in_ready`=1, `out_valid`=0, `sum`=0, `cout`=0.
  - state=IDLE; carry register, index and operand registers = 0.
- Reset asserted mid-RUN or in DONE aborts the operation immediately. The partial result is discarded and no `out_valid` is produced.
- `out_valid` held with `out_ready`=0 indefinitely: no change to `sum` or `cout`.
- Index wrap is not used: the transition to DONE occurs at idx = WORDS−1, so the index never exceeds WORDS−1.

## Structure
- Shared package `csa_pkg`:
  - `SLICE_W = 16`.
  - state enum `seq_state_t` {IDLE, RUN, DONE}.
- One sub-module: existing `carry_select_adder` (ports A[15:0], B[15:0], cin, S[15:0], cout), instantiated once.
- Datapath is the operand shift/index mux plus the result register.
- Control is a three-state FSM with a `$clog2(WORDS)` counter.

## Test plan
All scenarios use WORDS=4 (N=64) unless stated.
- Add with full carry ripple: a=0xFFFF_FFFF_FFFF_FFFF, b=1, op_sub=0 → sum=0, cout=1. `out_valid` rises exactly 5 cycles after accept.
- Subtract with borrow: a=0, b=1, op_sub=1 → sum=0xFFFF_FFFF_FFFF_FFFF, cout=0. Repeat with a=5, b=3 → sum=2, cout=1.
- Backpressure:
  - hold `out_ready`=0 for 3 cycles after `out_valid` → `sum`/`cout` stable, `in_ready`=0, and a new `in_valid` is ignored.
  - raise `out_ready` → next cycle `in_ready`=1.
- Reset mid-operation: assert `rst_n`=0 at RUN cycle 2 → all outputs take reset values and `out_valid` never asserts. The next operation 0x1234+0x4321 → sum=0x5555, cout=0.
- Back-to-back traffic: 1000 random operand pairs and ops, with `out_ready` randomly throttled → each result matches {cout,sum} of a+b or a+~b+1 (mod 2^65), in order, with no loss or duplication.
- WORDS=2 build: a=0x8000_0000, b=0x8000_0000 add → sum=0, cout=1. Latency is 3 cycles.
